// File: rtl/chunked_ripple_subtractor_pkg.sv
// Shared definitions for the chunked ripple subtractor: FSM state encoding
// and the chunk-count / counter-width helpers.
package sub_defs;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int nchunk(input int bw, input int cw);
        return bw / cw;
    endfunction

    // A single-chunk build still needs a 1-bit counter.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/chunked_ripple_subtractor_borrow_cell.sv
// One bit of the ripple-borrow chain: borrow out from generate/propagate
// terms and the borrow coming from the bit below.
module borrow_cell (
    input  logic Gi,
    input  logic Pi,
    input  logic Bp,
    output logic Bout
);

    assign Bout = Gi | (Pi & Bp);

endmodule

// File: rtl/chunked_ripple_subtractor.sv
// Multi-cycle subtractor: diff = A - B - bin, one CW-bit chunk per clock,
// borrow carried between chunks in a register. Optional SUB_OVF_FLAG_EN adds a
// registered signed-overflow flag on port ovf.
module chunked_ripple_subtractor
    import sub_defs::*;
#(
    parameter int BW = 32,
    parameter int CW = 8
) (
    input  logic        CLK,
    input  logic        RESETn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [BW:1] A,
    input  logic [BW:1] B,
    input  logic        bin,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [BW:1] diff,
    output logic        bout
`ifdef SUB_OVF_FLAG_EN
    ,
    output logic        ovf
`endif
);

    localparam int NCHUNK = nchunk(BW, CW);
    localparam int CNTW   = cnt_width(NCHUNK);

    state_t            state_reg, state_next;
    logic [CNTW-1:0]   cnt_reg;
    logic [BW:1]       a_reg, b_reg, diff_reg, diff_next;
    logic              borrow_reg, bout_reg;
    logic [CW-1:0]     a_chunk, b_chunk, g_chunk, p_chunk, d_chunk;
    logic [CW:0]       bc;
    logic              last_chunk;
`ifdef SUB_OVF_FLAG_EN
    logic              ovf_reg;
`endif

    assign last_chunk = (cnt_reg == CNTW'(NCHUNK - 1));

    // Select the operand chunk addressed by the counter.
    always_comb begin
        a_chunk = '0;
        b_chunk = '0;
        for (int k = 0; k < NCHUNK; k++) begin
            if (cnt_reg == CNTW'(k)) begin
                a_chunk = a_reg[k*CW+1 +: CW];
                b_chunk = b_reg[k*CW+1 +: CW];
            end
        end
    end

    assign bc[0] = borrow_reg;

    genvar gi;
    generate
        for (gi = 0; gi < CW; gi++) begin : g_bit
            assign g_chunk[gi] = ~a_chunk[gi] & b_chunk[gi];
            assign p_chunk[gi] = ~(a_chunk[gi] ^ b_chunk[gi]);
            assign d_chunk[gi] = a_chunk[gi] ^ b_chunk[gi] ^ bc[gi];
            borrow_cell u_cell (
                .Gi   (g_chunk[gi]),
                .Pi   (p_chunk[gi]),
                .Bp   (bc[gi]),
                .Bout (bc[gi+1])
            );
        end
    endgenerate

    // Write the freshly computed chunk back into its slot of diff.
    always_comb begin
        diff_next = diff_reg;
        for (int k = 0; k < NCHUNK; k++) begin
            if (cnt_reg == CNTW'(k)) begin
                diff_next[k*CW+1 +: CW] = d_chunk;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (in_valid)   state_next = RUN;
            RUN:     if (last_chunk) state_next = DONE;
            DONE:    if (out_ready)  state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            diff_reg   <= '0;
            borrow_reg <= 1'b0;
            bout_reg   <= 1'b0;
`ifdef SUB_OVF_FLAG_EN
            ovf_reg    <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        a_reg      <= A;
                        b_reg      <= B;
                        borrow_reg <= bin;
                        cnt_reg    <= '0;
                    end
                end
                RUN: begin
                    diff_reg   <= diff_next;
                    borrow_reg <= bc[CW];
                    if (last_chunk) begin
                        bout_reg <= bc[CW];
`ifdef SUB_OVF_FLAG_EN
                        ovf_reg  <= (a_reg[BW] ^ b_reg[BW]) & (a_reg[BW] ^ d_chunk[CW-1]);
`endif
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign diff      = diff_reg;
    assign bout      = bout_reg;
`ifdef SUB_OVF_FLAG_EN
    assign ovf       = ovf_reg;
`endif

endmodule

// File: tb/tb_chunked_ripple_subtractor.sv
// Self-checking bench: directed vector table, backpressure/reset sequences and
// random operands against an arithmetic reference model.
module tb_chunked_ripple_subtractor;

    localparam int BW     = 32;
    localparam int CW     = 8;
    localparam int NCHUNK = BW / CW;

    logic        CLK;
    logic        RESETn;
    logic        in_valid;
    logic        in_ready;
    logic [BW:1] A;
    logic [BW:1] B;
    logic        bin;
    logic        out_valid;
    logic        out_ready;
    logic [BW:1] diff;
    logic        bout;
`ifdef SUB_OVF_FLAG_EN
    logic        ovf;
`endif

    int checks = 0;
    int errors = 0;

    chunked_ripple_subtractor #(.BW(BW), .CW(CW)) dut (
        .CLK       (CLK),
        .RESETn    (RESETn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout)
`ifdef SUB_OVF_FLAG_EN
        ,
        .ovf       (ovf)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [BW:1] a;
        logic [BW:1] b;
        logic        bi;
        logic [BW:1] exp_diff;
        logic        exp_bout;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain wide arithmetic, borrow is the bit above the result.
    task automatic model(input logic [BW:1] a, input logic [BW:1] b, input logic bi,
                         output logic [BW:1] d, output logic bo, output logic ov);
        logic [BW:0] wide;
        longint sa, sb, sr;
        wide = {1'b0, a} - {1'b0, b} - {{BW{1'b0}}, bi};
        d    = wide[BW-1:0];
        bo   = wide[BW];
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        sr   = sa - sb - longint'(bi);
        ov   = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Accept one operand set and wait for the result; returns edges to out_valid.
    task automatic launch(input logic [BW:1] a, input logic [BW:1] b, input logic bi,
                          output int edges);
        check("in_ready_before_accept", 64'(in_ready), 64'd1);
        A        = a;
        B        = b;
        bin      = bi;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        edges = 0;
        while (!out_valid && edges < 20) begin
            tick();
            edges++;
        end
    endtask

    task automatic run_op(input string tag, input logic [BW:1] a, input logic [BW:1] b,
                          input logic bi, input logic check_lat);
        int          edges;
        logic [BW:1] ed;
        logic        eb, eo;
        model(a, b, bi, ed, eb, eo);
        launch(a, b, bi, edges);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd1);
        if (check_lat) check({tag, "_latency"}, 64'(edges), 64'(NCHUNK));
        check({tag, "_diff"}, 64'(diff), 64'(ed));
        check({tag, "_bout"}, 64'(bout), 64'(eb));
`ifdef SUB_OVF_FLAG_EN
        check({tag, "_ovf"}, 64'(ovf), 64'(eo));
`endif
        $display("op %s: A=%08h B=%08h bin=%0d -> diff=%08h bout=%0d (lat %0d)",
                 tag, a, b, bi, diff, bout, edges);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_back_to_idle"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        logic [BW:1] held_diff;
        logic        held_bout;
        int          edges;

        in_valid  = 1'b0;
        out_ready = 1'b0;
        A         = '0;
        B         = '0;
        bin       = 1'b0;
        RESETn    = 1'b0;

        vecs[0] = '{32'h00000005, 32'h00000003, 1'b0, 32'h00000002, 1'b0};
        vecs[1] = '{32'h00000000, 32'h00000001, 1'b0, 32'hFFFFFFFF, 1'b1};
        vecs[2] = '{32'h00000100, 32'h00000001, 1'b0, 32'h000000FF, 1'b0};
        vecs[3] = '{32'h12345678, 32'h12345678, 1'b1, 32'hFFFFFFFF, 1'b1};
        vecs[4] = '{32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 1'b0};
        vecs[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h00000000, 1'b0};
        vecs[6] = '{32'h00010000, 32'h00000000, 1'b1, 32'h0000FFFF, 1'b0};
        vecs[7] = '{32'h00000000, 32'hFFFFFFFF, 1'b1, 32'h00000000, 1'b1};

        #12;
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_in_ready",  64'(in_ready),  64'd1);
        check("reset_diff",      64'(diff),      64'd0);
        check("reset_bout",      64'(bout),      64'd0);
        @(negedge CLK);
        RESETn = 1'b1;
        tick();

        // Directed table with hand-derived expectations.
        for (int i = 0; i < 8; i++) begin
            launch(vecs[i].a, vecs[i].b, vecs[i].bi, edges);
            check($sformatf("vec%0d_latency", i), 64'(edges), 64'(NCHUNK));
            check($sformatf("vec%0d_diff", i), 64'(diff), 64'(vecs[i].exp_diff));
            check($sformatf("vec%0d_bout", i), 64'(bout), 64'(vecs[i].exp_bout));
`ifdef SUB_OVF_FLAG_EN
            if (i == 4) check("vec4_ovf", 64'(ovf), 64'd1);
`endif
            $display("vec %0d: A=%08h B=%08h bin=%0d -> diff=%08h bout=%0d",
                     i, vecs[i].a, vecs[i].b, vecs[i].bi, diff, bout);
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end

        // Backpressure in DONE: result held, new operands ignored.
        launch(32'h00000005, 32'h00000003, 1'b0, edges);
        held_diff = diff;
        held_bout = bout;
        check("bp_held_diff_init", 64'(held_diff), 64'h2);
        for (int c = 0; c < 5; c++) begin
            A        = 32'hDEADBEEF;
            B        = 32'h00000001;
            in_valid = c[0];
            tick();
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_in_ready",  64'(in_ready),  64'd0);
            check("bp_diff",      64'(diff),      64'(held_diff));
            check("bp_bout",      64'(bout),      64'(held_bout));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_release_in_ready", 64'(in_ready), 64'd1);
        tick();
        tick();
        check("bp_idle_stays", 64'(in_ready), 64'd1);
        check("bp_idle_diff_kept", 64'(diff), 64'h2);
        $display("backpressure: diff held at %08h through 5 stalled cycles", diff);

        // Reset in the middle of an operation.
        A        = 32'h00000000;
        B        = 32'h00000001;
        bin      = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        RESETn = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_diff",      64'(diff),      64'd0);
        check("midrst_bout",      64'(bout),      64'd0);
        check("midrst_in_ready",  64'(in_ready),  64'd1);
        $display("mid-run reset: diff=%08h bout=%0d in_ready=%0d", diff, bout, in_ready);
        @(negedge CLK);
        RESETn = 1'b1;
        tick();
        run_op("post_reset", 32'h00000100, 32'h00000001, 1'b0, 1'b1);

        // Random operands against the arithmetic model.
        for (int r = 0; r < 40; r++) begin
            logic [BW:1] ra, rb;
            ra = $urandom;
            rb = (r % 5 == 0) ? ra : BW'($urandom);
            run_op($sformatf("rnd%0d", r), ra, rb, 1'($urandom_range(0, 1)), 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete (got timeout, required finish)");
        $fatal(1, "watchdog");
    end

endmodule
